// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned radix-2 restoring divider with a start/done handshake.
// The design retires one quotient bit per clock, so a result takes n cycles after
// the accepting edge. A zero divisor completes in a single cycle with a flag.
module seq_restoring_divider #(
   parameter int n = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [n-1:0] dividend,
   input  logic [n-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [n-1:0] quotient,
   output logic [n-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = (n > 1) ? $clog2(n) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t         state;
   logic [n-1:0]   prem;       // partial remainder, always < dvsr
   logic [n-1:0]   shreg;      // dividend bits shift out, quotient bits shift in
   logic [n-1:0]   dvsr;
   logic [CW-1:0]  cnt;

   logic [n:0]     shifted;
   logic [n:0]     trial;
   logic           qbit;
   logic [n-1:0]   prem_nxt;
   logic [n-1:0]   shreg_nxt;

   // The trial is one bit wider than the operands, so its top bit is the sign
   // of (shifted - divisor) and no overflow can occur.
   function automatic logic [n:0] trial_sub(input logic [n:0] a, input logic [n-1:0] d);
      return a - {1'b0, d};
   endfunction

   // One restoring step: shift in the next dividend bit, try to subtract the divisor.
   always_comb begin
      shifted   = {prem, shreg[n-1]};
      trial     = trial_sub(shifted, dvsr);
      qbit      = ~trial[n];
      prem_nxt  = qbit ? trial[n-1:0] : shifted[n-1:0];
      shreg_nxt = {shreg[n-2:0], qbit};
   end

   // Control FSM and datapath registers; results are loaded only on completion.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         prem        <= '0;
         shreg       <= '0;
         dvsr        <= '0;
         cnt         <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     // Zero divisor never enters RUN: flag it and finish now.
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                  end else begin
                     shreg <= dividend;
                     dvsr  <= divisor;
                     prem  <= '0;
                     cnt   <= '0;
                     busy  <= 1'b1;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               prem  <= prem_nxt;
               shreg <= shreg_nxt;
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(n - 1)) begin
                  quotient    <= shreg_nxt;
                  remainder   <= prem_nxt;
                  div_by_zero <= 1'b0;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
